// File: rtl/cpu_fetch_unit_pkg.sv
// Shared CPU fetch definitions: reset vector, NOP word, queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  // One instruction queue entry: fetched word plus the address it came from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of targets are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Instruction queue: DEPTH x 64-bit entries, synchronous push/pop, single-cycle flush.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller's credit accounting keeps pushes within capacity.
// Ports: clk/rst (async active-high), flush, push/push_dat, pop, head_dat, count.
module cpu_fetch_fifo
  import cpu_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_dat,
  input  logic                         pop,
  output fetch_entry_t                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A push into a full queue is still legal when the head leaves in the same cycle.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch: issues sequential word fetches, queues in-order responses, handles redirects.
// Latency: grant -> response -> inst_valid the cycle after the response; 1 inst/cycle sustained.
// Backpressure: requests stop when outstanding or queue credit is exhausted; inst_ready pops the head.
// Ports: clk/rst; imem_req/addr/gnt/rvalid/rdata memory side; inst_valid/inst/inst_pc/inst_ready
//        decoder side; redirect_valid/redirect_pc; fetch_halt blocks new requests only.
module cpu_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = cpu_fetch_unit_pkg::RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_halt
);

  import cpu_fetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_OUT + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [IW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  q_push_dat;
  logic          q_push;
  logic          q_pop;
  logic [31:0]   credit;
  logic          rsp_take;
  logic          rsp_drop;
  logic          xfer;

  always_comb begin
    // Credit counts every slot already spoken for: queued words plus live responses
    // still in flight. Responses that will be dropped never need a slot.
    credit     = 32'(q_count) + 32'(inflight_q) - 32'(drop_cnt_q);
    imem_req   = !rst && !redirect_valid && !fetch_halt &&
                 (inflight_q < IW'(MAX_OUT)) && (credit < 32'(DEPTH));
    imem_addr  = fetch_pc_q;
    xfer       = imem_req && imem_gnt;

    // A response with nothing outstanding is stray and changes nothing.
    rsp_take   = imem_rvalid && (inflight_q != '0);
    rsp_drop   = rsp_take && (drop_cnt_q != '0);

    inst_valid = (q_count != '0);
    inst       = inst_valid ? q_head.inst : NOP_WORD;
    inst_pc    = inst_valid ? q_head.pc   : 32'h0;

    q_push          = rsp_take && !rsp_drop && !redirect_valid;
    q_pop           = inst_valid && inst_ready && !redirect_valid;
    q_push_dat.inst = imem_rdata;
    q_push_dat.pc   = rsp_pc_q;

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;

    if (redirect_valid) begin
      // Everything still outstanding belongs to the old path; the response that
      // lands this cycle (if any) is already discarded by not pushing it.
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      inflight_d = inflight_q - IW'(rsp_take);
      drop_cnt_d = inflight_q - IW'(rsp_take);
    end else begin
      if (xfer)     fetch_pc_d = fetch_pc_q + 32'd4;
      if (q_push)   rsp_pc_d   = rsp_pc_q + 32'd4;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - IW'(1);
      inflight_d = inflight_q + IW'(xfer) - IW'(rsp_take);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  cpu_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (q_push),
    .push_dat (q_push_dat),
    .pop      (q_pop),
    .head_dat (q_head),
    .count    (q_count)
  );

endmodule

// File: doc/cpu_fetch_unit.md
CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the instruction queue depth in entries (power of two, at least 2).
REQ-002 The block SHALL have parameter MAX_OUT, default 2, meaning the maximum number of outstanding memory requests.
REQ-003 The block SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-004 The block SHALL have one clock, port clk, input, width 1; all state changes on its rising edge.
REQ-005 The block SHALL have reset port rst, input, width 1; reset is asynchronous and active-high.
REQ-006 imem_req, output, width 1: fetch request.
REQ-007 imem_addr, output, width 32: word-aligned fetch address.
REQ-008 imem_gnt, input, width 1: memory accepts the request this cycle.
REQ-009 imem_rvalid, input, width 1: read data valid.
REQ-010 imem_rdata, input, width 32: instruction word, returned in request order.
REQ-011 inst_valid, output, width 1: queue head is valid.
REQ-012 inst, output, width 32: instruction word for the decoder.
REQ-013 inst_pc, output, width 32: address of inst.
REQ-014 inst_ready, input, width 1: decoder consumes the head.
REQ-015 redirect_valid, input, width 1: branch, jump or exception redirect.
REQ-016 redirect_pc, input, width 32: redirect target.
REQ-017 fetch_halt, input, width 1: suppress new requests.

Function
REQ-018 State SHALL consist of: fetch pc, response pc, queue count, inflight (0..MAX_OUT) and drop_cnt (0..inflight).
- Define credit = count + inflight - drop_cnt.
REQ-019 imem_req SHALL be combinational: asserted iff !redirect_valid && !fetch_halt && inflight < MAX_OUT && credit < DEPTH.
- imem_addr SHALL equal fetch pc.
REQ-020 A request SHALL be transferred only on imem_req && imem_gnt.
- On transfer: fetch pc += 4 (wraps modulo 2^32); inflight += 1.
REQ-021 On imem_rvalid with inflight > 0, inflight SHALL decrement.
- If drop_cnt > 0: data discarded, drop_cnt -= 1.
- Otherwise: push {imem_rdata, response pc}; response pc += 4.
REQ-022 imem_rvalid with inflight == 0 SHALL be ignored and SHALL leave all state unchanged.
REQ-023 inst_valid SHALL equal (count > 0); inst and inst_pc SHALL present the head entry.
- When the queue is empty, inst SHALL be 32'h00000000 (NOP) and inst_pc 0.
REQ-024 inst_valid && inst_ready SHALL pop the head.
- Push and pop in the same cycle SHALL leave count unchanged, including when count == DEPTH.
REQ-025 The credit rule SHALL guarantee the queue never overflows; inst_ready while empty SHALL be ignored.
REQ-026 Redirect SHALL have priority over push, pop and issue in the same cycle:
- queue flushed (count = 0);
- fetch pc and response pc = {redirect_pc[31:2], 2'b00};
- drop_cnt = inflight minus 1 if imem_rvalid this cycle;
- no request issued.
REQ-027 The first instruction delivered after a redirect SHALL be the target's word; no stale word SHALL ever reach inst.
REQ-028 fetch_halt SHALL block only new requests; responses SHALL still be queued and the queue SHALL still drain.
REQ-029 Back-to-back redirects SHALL each apply; the last one sets the pc.
REQ-030 Sustained throughput SHALL be one instruction per cycle with zero-latency memory and inst_ready held high.

Reset
REQ-031 While rst is high:
- fetch pc and response pc = RESET_PC;
- count, inflight and drop_cnt = 0;
- inst_valid = 0, inst = 0, inst_pc = 0.
REQ-032 imem_req SHALL be 0 while rst is high and MAY assert in the first cycle after release.
REQ-033 Reset mid-operation SHALL abandon all inflight responses.
- The memory is reset by the same rst.

Structure
REQ-034 RESET_PC default and the NOP word constant SHALL live in the shared CPU package.
REQ-035 The queue SHALL be a sub-module, cpu_fetch_fifo: DEPTH entries of 64 bits, synchronous push/pop, single-cycle flush, count output.
REQ-036 Credit and drop accounting SHALL remain in cpu_fetch_unit.

Verification
REQ-037 Reset release, gnt=1, rvalid one cycle after grant, inst_ready=1 -> addresses BFC00000, BFC00004, ... and inst_pc follows, one instruction per cycle.
REQ-038 inst_ready=0 with DEPTH=4 -> exactly 4 entries queued; imem_req stays low; no word lost when inst_ready returns to 1.
REQ-039 Redirect to 80000010 with 2 requests inflight -> both responses dropped; next inst_pc = 80000010; first new imem_addr = 80000010.
REQ-040 Redirect coinciding with rvalid and pop -> queue empty next cycle; drop_cnt = 1; no stale word at inst.
REQ-041 fetch_halt=1 with 1 inflight -> the response is queued and delivered; no new request; fetching resumes at the next sequential pc on release.
REQ-042 rst asserted mid-stream, then a stray rvalid after release -> stray response ignored; fetch restarts at BFC00000.
